speed_step_scheduler: RTL
=========================

Name: speed_step_scheduler

Overview:
- Sequences the vehicle speed register. On each update tick it arbitrates between four speed-change requesters: safety decel, driver brake, driver accelerator, and the cruise-control loop.
- Adds friction coast-down when nothing is requesting.
- Applies a reversal dead-time, saturates at 0 and MAX_SPEED, and issues at most one ±1 step per tick.
- Sits between the cruise-control FSM / pedal inputs and the speed display datapath; it is the sole writer of speed.

Parameters:
- SPEED_W, 7, width of speed
- MAX_SPEED, 64, upper saturation value (must be < 2^SPEED_W)
- COAST_DIV, 2, idle ticks per friction decrement (≥1)
- DEAD_TICKS, 1, ticks with no step after a direct up↔down reversal (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle update strobe (e.g. 2 Hz), synchronous to clk
- safety_req  in  1  collision/too-close decel request
- brake_req  in  1  driver brake pedal
- accel_req  in  1  driver accelerator pedal
- cc_active  in  1  cruise control engaged
- cc_up_req  in  1  CC loop wants +1
- cc_down_req  in  1  CC loop wants -1
- speed  out  SPEED_W  current speed
- step_up  out  1  one-cycle pulse: speed incremented
- step_down  out  1  one-cycle pulse: speed decremented
- grant  out  5  one-hot winner {coast, cc, accel, brake, safety}, bit0 = safety; 0 = none
- state  out  2  0 IDLE, 1 UP, 2 DOWN, 3 SETTLE
- sat_hi  out  1  speed == MAX_SPEED
- sat_lo  out  1  speed == 0

Behaviour:
- Reset (async, rst_n=0): speed=0, state=IDLE, step_up=step_down=0, grant=0, coast_cnt=0, dead_cnt=0. sat_lo=1, sat_hi=0 (combinational from speed). Ticks while in reset are ignored; reset mid-SETTLE aborts it.
- All arbitration and state updates occur only on clk edges where tick=1. Between ticks, speed/state/grant hold; step pulses are 0.
- Latency: tick sampled at edge N → speed, step_*, grant, state updated at edge N (registered), visible cycle N+1. step_* high for exactly one cycle.
- Fixed priority at tick, with the resulting direction:
  - safety → down
  - brake → down
  - accel → up
  - cc: only if cc_active. up if cc_up_req&!cc_down_req; down if cc_down_req&!cc_up_req; both or neither → no cc request.
  - coast → down. Only if !cc_active, no other winner, and coast_cnt==COAST_DIV-1.
- coast_cnt: increments on ticks with no winner and !cc_active, wrapping to 0 when coast wins. Clears on any non-coast winner or when cc_active=1.
- grant is the one-hot winner, or 0 when no winner. It holds until the next tick.
- State transitions (dir = winner direction):
  - IDLE: none→IDLE; up→UP with step; down→DOWN with step.
  - UP: up→UP with step; none→IDLE; down from safety→DOWN with step (exempt from dead-time); other down→SETTLE with no step, dead_cnt=1.
  - DOWN: mirror of UP. up→SETTLE with no step, dead_cnt=1 (accel is not exempt).
  - SETTLE:
    - safety→DOWN with step, immediately.
    - Otherwise, if dead_cnt<DEAD_TICKS: stay, dead_cnt+1, no step.
    - Otherwise evaluate as IDLE on this tick.
- Saturation: an up step at speed==MAX_SPEED is suppressed (no pulse, speed unchanged). A down step at speed==0 is likewise suppressed. State still follows dir and grant still reports the winner. speed never wraps.
- step_up and step_down are never both 1.

Test Plan:
- Reset, accel_req=1, 3 ticks → speed 0→1→2→3; step_up pulses each tick; grant=00100; state=UP.
- At speed 3 in UP, brake_req=1 on tick A → SETTLE, speed 3, no step. Tick A+1 → DOWN, speed 2, step_down.
- At speed 10 in UP, accel_req=1 and safety_req=1 → speed 9 same tick, state=DOWN, grant=00001 (safety beats accel, no dead-time).
- cc_active=0, all requests 0, speed 5, 4 ticks → speed 5,4,4,3: coast every 2nd tick, grant alternates 0/10000. With cc_active=1 and no cc request, speed holds at 5.
- Speed 64, accel_req=1, tick → speed 64, no step_up, sat_hi=1, state=UP. Speed 0, brake_req=1 → no step_down, sat_lo=1.
- cc_active=1, cc_up_req=cc_down_req=1 → grant=0, no step. Assert rst_n=0 mid-SETTLE → all outputs reset asynchronously; the next tick after release starts from IDLE.

Source files
------------

// File: rtl/speed_step_scheduler.sv
// speed_step_scheduler
// Sole writer of the vehicle speed register. Each tick it arbitrates between
// safety decel, driver brake, driver accelerator, the cruise-control loop and
// friction coast-down. It then applies a reversal dead-time and saturation,
// and issues at most one +/-1 step.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no step direction in force
// UP    | last tick stepped (or tried to step) up
// DOWN  | last tick stepped (or tried to step) down
// SETTLE| dead-time after an up<->down reversal, steps blocked except safety
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   tick              one-cycle update strobe
//   safety_req        collision decel request (highest priority)
//   brake_req         driver brake
//   accel_req         driver accelerator
//   cc_active         cruise control engaged
//   cc_up_req         cruise loop wants +1
//   cc_down_req       cruise loop wants -1
//   speed             current speed
//   step_up/step_down one-cycle pulse when speed actually changed
//   grant             one-hot winner {coast, cc, accel, brake, safety}
//   state             0 IDLE, 1 UP, 2 DOWN, 3 SETTLE
//   sat_hi/sat_lo     speed at MAX_SPEED / at 0
module speed_step_scheduler #(
  parameter int SPEED_W    = 7,
  parameter int MAX_SPEED  = 64,
  parameter int COAST_DIV  = 2,
  parameter int DEAD_TICKS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               safety_req,
  input  logic               brake_req,
  input  logic               accel_req,
  input  logic               cc_active,
  input  logic               cc_up_req,
  input  logic               cc_down_req,
  output logic [SPEED_W-1:0] speed,
  output logic               step_up,
  output logic               step_down,
  output logic [4:0]         grant,
  output logic [1:0]         state,
  output logic               sat_hi,
  output logic               sat_lo
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UP     = 2'd1,
    S_DOWN   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  localparam int CW = (COAST_DIV > 1) ? $clog2(COAST_DIV) : 1;
  localparam int DW = $clog2(DEAD_TICKS + 1);

  state_t        state_q, state_n;
  logic [CW-1:0] coast_cnt, coast_cnt_n;
  logic [DW-1:0] dead_cnt, dead_cnt_n;

  logic [4:0] win;
  logic       dir_up, dir_dn;
  logic       cc_up, cc_dn;
  logic       do_up, do_dn;

  assign cc_up = cc_active & cc_up_req & ~cc_down_req;
  assign cc_dn = cc_active & cc_down_req & ~cc_up_req;

  // Fixed-priority arbitration; coast only fills a gap nobody else claims.
  always_comb begin
    win    = 5'b00000;
    dir_up = 1'b0;
    dir_dn = 1'b0;
    if (safety_req) begin
      win = 5'b00001; dir_dn = 1'b1;
    end else if (brake_req) begin
      win = 5'b00010; dir_dn = 1'b1;
    end else if (accel_req) begin
      win = 5'b00100; dir_up = 1'b1;
    end else if (cc_up) begin
      win = 5'b01000; dir_up = 1'b1;
    end else if (cc_dn) begin
      win = 5'b01000; dir_dn = 1'b1;
    end else if (!cc_active && coast_cnt == CW'(COAST_DIV - 1)) begin
      win = 5'b10000; dir_dn = 1'b1;
    end
  end

  // Counts idle ticks; any winner (coast included) or an engaged CC restarts it.
  assign coast_cnt_n = (win == 5'b00000 && !cc_active) ? coast_cnt + 1'b1 : '0;

  always_comb begin
    state_n    = state_q;
    dead_cnt_n = dead_cnt;
    do_up      = 1'b0;
    do_dn      = 1'b0;
    case (state_q)
      S_UP: begin
        if (dir_up) begin
          do_up = 1'b1;
        end else if (dir_dn && win[0]) begin
          state_n = S_DOWN;
          do_dn   = 1'b1;
        end else if (dir_dn) begin
          state_n    = S_SETTLE;
          dead_cnt_n = DW'(1);
        end else begin
          state_n = S_IDLE;
        end
      end
      S_DOWN: begin
        if (dir_dn) begin
          do_dn = 1'b1;
        end else if (dir_up) begin
          state_n    = S_SETTLE;
          dead_cnt_n = DW'(1);
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (win[0]) begin
          state_n    = S_DOWN;
          do_dn      = 1'b1;
          dead_cnt_n = '0;
        end else if (dead_cnt < DW'(DEAD_TICKS)) begin
          dead_cnt_n = dead_cnt + 1'b1;
        end else begin
          // Dead-time served: behave exactly like IDLE on this tick.
          dead_cnt_n = '0;
          if (dir_up) begin
            state_n = S_UP;
            do_up   = 1'b1;
          end else if (dir_dn) begin
            state_n = S_DOWN;
            do_dn   = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        if (dir_up) begin
          state_n = S_UP;
          do_up   = 1'b1;
        end else if (dir_dn) begin
          state_n = S_DOWN;
          do_dn   = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      coast_cnt <= '0;
      dead_cnt  <= '0;
      grant     <= 5'b00000;
      speed     <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
    end else if (tick) begin
      state_q   <= state_n;
      coast_cnt <= coast_cnt_n;
      dead_cnt  <= dead_cnt_n;
      grant     <= win;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      // Saturated steps are swallowed; state and grant still follow the request.
      if (do_up && speed != SPEED_W'(MAX_SPEED)) begin
        speed   <= speed + 1'b1;
        step_up <= 1'b1;
      end else if (do_dn && speed != '0) begin
        speed     <= speed - 1'b1;
        step_down <= 1'b1;
      end
    end else begin
      step_up   <= 1'b0;
      step_down <= 1'b0;
    end
  end

  assign state  = state_q;
  assign sat_hi = (speed == SPEED_W'(MAX_SPEED));
  assign sat_lo = (speed == '0);

endmodule
